// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, states, IR field positions.
// Latency: n/a (constants, types and one pure decode function).
// Backpressure: n/a.
package cpu_pkg;

  // Instruction opcodes, IR[31:27]
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // IR field positions (MSB of each field; register fields run downward)
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int RA_HI  = 26;
  localparam int RB_HI  = 22;
  localparam int RC_HI  = 18;

  // Sequencer states
  typedef enum logic [3:0] {
    RESET, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  // Micro-sequence families; every opcode maps onto exactly one
  typedef enum logic [2:0] {
    CL_NOP, CL_ALU, CL_MULDIV, CL_LDI, CL_LD, CL_ST, CL_HALT
  } op_class_t;

  // Undefined opcodes fall into CL_NOP so they simply retire after T3
  function automatic op_class_t op_class(input logic [4:0] op);
    op_class_t c;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
      OP_ROL, OP_SHR, OP_SHRA, OP_SHL:  c = CL_ALU;
      OP_MUL, OP_DIV:                   c = CL_MULDIV;
      OP_LDI:                           c = CL_LDI;
      OP_LD:                            c = CL_LD;
      OP_ST:                            c = CL_ST;
      OP_HALT:                          c = CL_HALT;
      default:                          c = CL_NOP;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register-select decoder: binary index plus enable to a one-hot strobe vector.
// Latency: combinational, zero cycles.
// Backpressure: none; output is all-zero while enable is low.
module reg_onehot_dec #(
  parameter int W = 4
) (
  input  logic [W-1:0]    idx,
  input  logic            en,
  output logic [2**W-1:0] onehot
);

  // Raise exactly the selected bit when enabled, nothing otherwise
  always_comb begin
    onehot = '0;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch, decode IR, step T0..T7 and emit datapath strobes.
// Latency: one state per cycle; strobes are a combinational decode of state and IR.
// Backpressure: none; stop at T0 or a halt opcode parks in HALT until clr.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [31:0]          IR,
  input  logic                 stop,
  output logic                 PCout,
  output logic                 Zlowout,
  output logic                 ZHighout,
  output logic                 MDRout,
  output logic                 Cout,
  output logic                 Hiout,
  output logic                 Loout,
  output logic                 InPortout,
  output logic                 MARin,
  output logic                 PCin,
  output logic                 MDRin,
  output logic                 IRin,
  output logic                 Yin,
  output logic                 Zlowin,
  output logic                 ZHighin,
  output logic                 HIin,
  output logic                 LOin,
  output logic                 IncPC,
  output logic                 Read,
  output logic                 Write,
  output logic [4:0]           opCode,
  output logic [2**ADDR_W-1:0] Rout,
  output logic [2**ADDR_W-1:0] enableReg,
  output logic                 run
);

  state_t            state;
  state_t            state_nxt;
  op_class_t         cls;
  logic [4:0]        ir_op;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  logic [ADDR_W-1:0] rc;
  logic [ADDR_W-1:0] rout_idx;
  logic              rout_en;
  logic [ADDR_W-1:0] wr_idx;
  logic              wr_en;
  logic              ir_unused;

  assign ir_op     = IR[OPC_HI:OPC_LO];
  assign ra        = IR[RA_HI -: ADDR_W];
  assign rb        = IR[RB_HI -: ADDR_W];
  assign rc        = IR[RC_HI -: ADDR_W];
  assign cls       = op_class(ir_op);
  // Constant/immediate bits are consumed by the datapath, not by control
  assign ir_unused = ^IR[RC_HI-ADDR_W:0];

  // Sequence successor: fetch is common, the tail depends on the opcode family
  always_comb begin
    state_nxt = state;
    case (state)
      RESET: state_nxt = T0;
      T0:    state_nxt = stop ? HALT : T1;
      T1:    state_nxt = T2;
      T2:    state_nxt = T3;
      T3: begin
        case (cls)
          CL_NOP:  state_nxt = T0;
          CL_HALT: state_nxt = HALT;
          default: state_nxt = T4;
        endcase
      end
      T4:    state_nxt = T5;
      T5:    state_nxt = (cls == CL_ALU || cls == CL_LDI) ? T0 : T6;
      T6:    state_nxt = (cls == CL_MULDIV) ? T0 : T7;
      T7:    state_nxt = T0;
      HALT:  state_nxt = HALT;
      default: state_nxt = RESET;
    endcase
  end

  // State register; clr wins over everything, including mid-instruction
  always_ff @(posedge clk) begin
    if (clr) state <= RESET;
    else     state <= state_nxt;
  end

  // Strobe decode; anything not named for a state stays low
  always_comb begin
    PCout     = 1'b0;
    Zlowout   = 1'b0;
    ZHighout  = 1'b0;
    MDRout    = 1'b0;
    Cout      = 1'b0;
    Hiout     = 1'b0;
    Loout     = 1'b0;
    InPortout = 1'b0;
    MARin     = 1'b0;
    PCin      = 1'b0;
    MDRin     = 1'b0;
    IRin      = 1'b0;
    Yin       = 1'b0;
    Zlowin    = 1'b0;
    ZHighin   = 1'b0;
    HIin      = 1'b0;
    LOin      = 1'b0;
    IncPC     = 1'b0;
    Read      = 1'b0;
    Write     = 1'b0;
    opCode    = 5'b00000;
    rout_en   = 1'b0;
    rout_idx  = '0;
    wr_en     = 1'b0;
    wr_idx    = '0;
    run       = (state != HALT);
    case (state)
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        // First operand into Y; mul/div take Ra, everything else Rb
        if (cls != CL_NOP && cls != CL_HALT) begin
          Yin      = 1'b1;
          rout_en  = 1'b1;
          rout_idx = (cls == CL_MULDIV) ? ra : rb;
        end
      end
      T4: begin
        Zlowin = 1'b1;
        case (cls)
          CL_ALU: begin
            rout_en  = 1'b1;
            rout_idx = rc;
            opCode   = ir_op;
          end
          CL_MULDIV: begin
            rout_en  = 1'b1;
            rout_idx = rb;
            ZHighin  = 1'b1;
            opCode   = ir_op;
          end
          CL_LDI, CL_LD, CL_ST: begin
            // Effective address / immediate: Rb + C through the adder
            Cout   = 1'b1;
            opCode = OP_ADD;
          end
          default: Zlowin = 1'b0;
        endcase
      end
      T5: begin
        case (cls)
          CL_ALU, CL_LDI: begin
            Zlowout = 1'b1;
            wr_en   = 1'b1;
            wr_idx  = ra;
          end
          CL_MULDIV: begin
            Zlowout = 1'b1;
            LOin    = 1'b1;
          end
          CL_LD, CL_ST: begin
            Zlowout = 1'b1;
            MARin   = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CL_MULDIV: begin
            ZHighout = 1'b1;
            HIin     = 1'b1;
          end
          CL_LD: begin
            Read  = 1'b1;
            MDRin = 1'b1;
          end
          CL_ST: begin
            // Read low so MDR captures the bus rather than memory
            rout_en  = 1'b1;
            rout_idx = ra;
            MDRin    = 1'b1;
          end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          CL_LD: begin
            MDRout = 1'b1;
            wr_en  = 1'b1;
            wr_idx = ra;
          end
          CL_ST: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  reg_onehot_dec #(.W(ADDR_W)) u_rout_dec (
    .idx    (rout_idx),
    .en     (rout_en),
    .onehot (Rout)
  );

  reg_onehot_dec #(.W(ADDR_W)) u_wr_dec (
    .idx    (wr_idx),
    .en     (wr_en),
    .onehot (enableReg)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected strobes queued per cycle, monitor compares.
// Latency: expectations are tagged with the absolute cycle they apply to.
// Backpressure: n/a; a watchdog bounds the run.
module tb_control_sequencer;

  localparam logic [19:0] M_PCOUT    = 20'h00001;
  localparam logic [19:0] M_ZLOWOUT  = 20'h00002;
  localparam logic [19:0] M_ZHIGHOUT = 20'h00004;
  localparam logic [19:0] M_MDROUT   = 20'h00008;
  localparam logic [19:0] M_COUT     = 20'h00010;
  localparam logic [19:0] M_MARIN    = 20'h00100;
  localparam logic [19:0] M_PCIN     = 20'h00200;
  localparam logic [19:0] M_MDRIN    = 20'h00400;
  localparam logic [19:0] M_IRIN     = 20'h00800;
  localparam logic [19:0] M_YIN      = 20'h01000;
  localparam logic [19:0] M_ZLOWIN   = 20'h02000;
  localparam logic [19:0] M_ZHIGHIN  = 20'h04000;
  localparam logic [19:0] M_HIIN     = 20'h08000;
  localparam logic [19:0] M_LOIN     = 20'h10000;
  localparam logic [19:0] M_INCPC    = 20'h20000;
  localparam logic [19:0] M_READ     = 20'h40000;
  localparam logic [19:0] M_WRITE    = 20'h80000;

  localparam logic [19:0] F0 = M_PCOUT | M_MARIN | M_INCPC | M_ZLOWIN;
  localparam logic [19:0] F1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
  localparam logic [19:0] F2 = M_MDROUT | M_IRIN;

  logic clk = 1'b0;
  logic clr, stop;
  logic [31:0] IR;
  logic PCout, Zlowout, ZHighout, MDRout, Cout, Hiout, Loout, InPortout;
  logic MARin, PCin, MDRin, IRin, Yin, Zlowin, ZHighin, HIin, LOin, IncPC, Read, Write;
  logic [4:0]  opCode;
  logic [15:0] Rout, enableReg;
  logic run;

  control_sequencer #(.ADDR_W(4)) dut (
    .clk(clk), .clr(clr), .IR(IR), .stop(stop),
    .PCout(PCout), .Zlowout(Zlowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .Cout(Cout), .Hiout(Hiout), .Loout(Loout), .InPortout(InPortout),
    .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .ZHighin(ZHighin), .HIin(HIin), .LOin(LOin),
    .IncPC(IncPC), .Read(Read), .Write(Write), .opCode(opCode),
    .Rout(Rout), .enableReg(enableReg), .run(run)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [19:0] s;
    logic [15:0] ro;
    logic [15:0] en;
    logic [4:0]  op;
    logic        rn;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned c0 = 0;
  int          checks = 0;
  int          failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic advance(input int n);
    repeat (n) tick();
    c0 = cyc;
  endtask

  task automatic expect_at(input int unsigned dc, input string tag, input logic [19:0] s,
                           input logic [15:0] ro, input logic [15:0] en,
                           input logic [4:0] op, input logic rn);
    exp_t e;
    e.cyc = c0 + dc; e.s = s; e.ro = ro; e.en = en; e.op = op; e.rn = rn; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic push_fetch(input string tag);
    expect_at(0, {tag, "_t0"}, F0, 16'h0, 16'h0, 5'b0, 1'b1);
    expect_at(1, {tag, "_t1"}, F1, 16'h0, 16'h0, 5'b0, 1'b1);
    expect_at(2, {tag, "_t2"}, F2, 16'h0, 16'h0, 5'b0, 1'b1);
  endtask

  // Monitor: per-cycle invariants plus in-order scoreboard comparison
  always @(negedge clk) begin
    logic [19:0] act;
    exp_t e;
    act = {Write, Read, IncPC, LOin, HIin, ZHighin, Zlowin, Yin, IRin, MDRin, PCin, MARin,
           InPortout, Loout, Hiout, Cout, MDRout, ZHighout, Zlowout, PCout};
    checks++;
    if (!$onehot0(Rout) || (Read && Write) || (Rout != 16'h0 && enableReg != 16'h0)) begin
      failures++;
      $display("FAIL invariant cyc=%0d: Rout=%h enableReg=%h Read=%b Write=%b; need Rout onehot0, not both Read/Write, not both regs",
               cyc, Rout, enableReg, Read, Write);
    end
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++;
      failures++;
      $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.tag, e.cyc, cyc);
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      checks++;
      if (act !== e.s || Rout !== e.ro || enableReg !== e.en || opCode !== e.op || run !== e.rn) begin
        failures++;
        $display("FAIL %s cyc=%0d: got strobes=%h Rout=%h en=%h op=%b run=%b, want strobes=%h Rout=%h en=%h op=%b run=%b",
                 e.tag, cyc, act, Rout, enableReg, opCode, run, e.s, e.ro, e.en, e.op, e.rn);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b1; stop = 1'b0; IR = 32'h0;
    // Two RESET cycles with all strobes low, then T0
    tick(); c0 = cyc;
    expect_at(0, "rst0", 20'h0, 16'h0, 16'h0, 5'b0, 1'b1);
    expect_at(1, "rst1", 20'h0, 16'h0, 16'h0, 5'b0, 1'b1);
    tick(); clr = 1'b0;
    advance(1);

    // and R1,R2,R3
    IR = 32'h28918000;
    push_fetch("and");
    expect_at(3, "and_t3", M_YIN,     16'h0004, 16'h0,    5'b00000, 1'b1);
    expect_at(4, "and_t4", M_ZLOWIN,  16'h0008, 16'h0,    5'b00101, 1'b1);
    expect_at(5, "and_t5", M_ZLOWOUT, 16'h0,    16'h0002, 5'b00000, 1'b1);
    advance(6);

    // ror R1,R2,R3
    IR = 32'h40918000;
    push_fetch("ror");
    expect_at(3, "ror_t3", M_YIN,     16'h0004, 16'h0,    5'b00000, 1'b1);
    expect_at(4, "ror_t4", M_ZLOWIN,  16'h0008, 16'h0,    5'b01000, 1'b1);
    expect_at(5, "ror_t5", M_ZLOWOUT, 16'h0,    16'h0002, 5'b00000, 1'b1);
    advance(6);

    // ld R1,0x55(R0)
    IR = 32'h00800055;
    push_fetch("ld");
    expect_at(3, "ld_t3", M_YIN,               16'h0001, 16'h0,    5'b00000, 1'b1);
    expect_at(4, "ld_t4", M_COUT | M_ZLOWIN,   16'h0,    16'h0,    5'b00011, 1'b1);
    expect_at(5, "ld_t5", M_ZLOWOUT | M_MARIN, 16'h0,    16'h0,    5'b00000, 1'b1);
    expect_at(6, "ld_t6", M_READ | M_MDRIN,    16'h0,    16'h0,    5'b00000, 1'b1);
    expect_at(7, "ld_t7", M_MDROUT,            16'h0,    16'h0002, 5'b00000, 1'b1);
    advance(8);

    // mul R3,R4
    IR = 32'h79A00000;
    push_fetch("mul");
    expect_at(3, "mul_t3", M_YIN,                  16'h0008, 16'h0, 5'b00000, 1'b1);
    expect_at(4, "mul_t4", M_ZLOWIN | M_ZHIGHIN,   16'h0010, 16'h0, 5'b01111, 1'b1);
    expect_at(5, "mul_t5", M_ZLOWOUT | M_LOIN,     16'h0,    16'h0, 5'b00000, 1'b1);
    expect_at(6, "mul_t6", M_ZHIGHOUT | M_HIIN,    16'h0,    16'h0, 5'b00000, 1'b1);
    advance(7);

    // div R6,R7
    IR = 32'h83380000;
    push_fetch("div");
    expect_at(3, "div_t3", M_YIN,                  16'h0040, 16'h0, 5'b00000, 1'b1);
    expect_at(4, "div_t4", M_ZLOWIN | M_ZHIGHIN,   16'h0080, 16'h0, 5'b10000, 1'b1);
    expect_at(5, "div_t5", M_ZLOWOUT | M_LOIN,     16'h0,    16'h0, 5'b00000, 1'b1);
    expect_at(6, "div_t6", M_ZHIGHOUT | M_HIIN,    16'h0,    16'h0, 5'b00000, 1'b1);
    advance(7);

    // st R2,0x10(R5)
    IR = 32'h11280010;
    push_fetch("st");
    expect_at(3, "st_t3", M_YIN,               16'h0020, 16'h0, 5'b00000, 1'b1);
    expect_at(4, "st_t4", M_COUT | M_ZLOWIN,   16'h0,    16'h0, 5'b00011, 1'b1);
    expect_at(5, "st_t5", M_ZLOWOUT | M_MARIN, 16'h0,    16'h0, 5'b00000, 1'b1);
    expect_at(6, "st_t6", M_MDRIN,             16'h0004, 16'h0, 5'b00000, 1'b1);
    expect_at(7, "st_t7", M_WRITE,             16'h0,    16'h0, 5'b00000, 1'b1);
    advance(8);

    // ldi R0,5(R0): register 0 handled like any other
    IR = 32'h08000005;
    push_fetch("ldi");
    expect_at(3, "ldi_t3", M_YIN,             16'h0001, 16'h0,    5'b00000, 1'b1);
    expect_at(4, "ldi_t4", M_COUT | M_ZLOWIN, 16'h0,    16'h0,    5'b00011, 1'b1);
    expect_at(5, "ldi_t5", M_ZLOWOUT,         16'h0,    16'h0001, 5'b00000, 1'b1);
    advance(6);

    // nop
    IR = 32'hD0000000;
    push_fetch("nop");
    expect_at(3, "nop_t3", 20'h0, 16'h0, 16'h0, 5'b0, 1'b1);
    advance(4);

    // undefined opcode 11111 behaves as nop
    IR = 32'hF8000000;
    push_fetch("undef");
    expect_at(3, "undef_t3", 20'h0, 16'h0, 16'h0, 5'b0, 1'b1);
    advance(4);

    // add R4,R5,R6 with clr in T4: no enableReg pulse
    IR = 32'h1A2B0000;
    push_fetch("addclr");
    expect_at(3, "addclr_t3", M_YIN,    16'h0020, 16'h0, 5'b00000, 1'b1);
    expect_at(4, "addclr_t4", M_ZLOWIN, 16'h0040, 16'h0, 5'b00011, 1'b1);
    expect_at(5, "addclr_rst", 20'h0,   16'h0,    16'h0, 5'b00000, 1'b1);
    repeat (4) tick();
    clr = 1'b1;
    tick(); clr = 1'b0;
    advance(1);

    // stop sampled in T0 -> HALT for 20 cycles, then clr
    IR = 32'h28918000;
    stop = 1'b1;
    expect_at(0, "stop_t0", F0, 16'h0, 16'h0, 5'b0, 1'b1);
    for (int i = 1; i <= 20; i++)
      expect_at(i, $sformatf("stop_halt%0d", i), 20'h0, 16'h0, 16'h0, 5'b0, 1'b0);
    expect_at(21, "stop_rst", 20'h0, 16'h0, 16'h0, 5'b0, 1'b1);
    tick(); stop = 1'b0;
    repeat (19) tick();
    clr = 1'b1;
    tick(); clr = 1'b0;
    advance(1);

    // halt opcode
    IR = 32'hD8000000;
    push_fetch("halt");
    expect_at(3, "halt_t3", 20'h0, 16'h0, 16'h0, 5'b0, 1'b1);
    for (int i = 4; i <= 8; i++)
      expect_at(i, $sformatf("halt_h%0d", i), 20'h0, 16'h0, 16'h0, 5'b0, 1'b0);
    expect_at(9, "halt_rst", 20'h0, 16'h0, 16'h0, 5'b0, 1'b1);
    repeat (8) tick();
    clr = 1'b1;
    tick(); clr = 1'b0;
    advance(1);

    // back in T0 after the single RESET cycle
    expect_at(0, "final_t0", F0, 16'h0, 16'h0, 5'b0, 1'b1);
    tick(); tick();
    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that produces the per-cycle datapath control strobes. Today the testbench supplies these strobes by hand through its T0–T5 sequence. The block fetches an instruction, decodes the opcode and register fields from the IR bus, and steps through the matching micro-sequence. It sits beside `datapath` and connects one-to-one to the datapath's control ports, replacing the hand-written stimulus FSM.

## Interface
- `ADDR_W`, default 4: register-select field width; register-file strobes are `2**ADDR_W` bits.
- `clk`  in  1  single clock; all state updates on its rising edge.
- `clr`  in  1  synchronous reset, active-high.
- `IR`  in  32  instruction register contents from the datapath.
- `stop`  in  1  halt request, sampled at T0.
- `PCout, Zlowout, ZHighout, MDRout, Cout, Hiout, Loout, InPortout`  out  1 each  bus-drive strobes.
- `MARin, PCin, MDRin, IRin, Yin, Zlowin, ZHighin, HIin, LOin, IncPC, Read, Write`  out  1 each  load and memory strobes.
- `opCode`  out  5  ALU operation.
- `Rout`  out  16  one-hot register bus-drive.
- `enableReg`  out  16  one-hot register load.
- `run`  out  1  high unless halted.

## Operation
- IR fields:
  - opcode = IR[31:27]
  - Ra = IR[26:23]
  - Rb = IR[22:19]
  - Rc = IR[18:15]
- Each state lasts exactly one cycle. Outputs are a combinational decode of state and IR. Every strobe not listed for a state is 0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zlowin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
  - IR is valid from T3.
- R-type ALU ops (add, sub, and, or, ror, rol, shr, shra, shl):
  - T3: Rout[Rb], Yin.
  - T4: Rout[Rc], Zlowin, opCode = IR opcode.
  - T5: Zlowout, enableReg[Ra].
  - Then T0.
- mul/div:
  - T3: Rout[Ra], Yin.
  - T4: Rout[Rb], Zlowin, ZHighin, opCode.
  - T5: Zlowout, LOin.
  - T6: ZHighout, HIin.
- ldi Ra, C(Rb):
  - T3: Rout[Rb], Yin.
  - T4: Cout, opCode = ADD, Zlowin.
  - T5: Zlowout, enableReg[Ra].
- ld:
  - T3–T4 as for ldi.
  - T5: Zlowout, MARin.
  - T6: Read, MDRin.
  - T7: MDRout, enableReg[Ra].
- st:
  - T3–T5 as for ld.
  - T6: Rout[Ra], MDRin with Read = 0, so MDR takes the bus.
  - T7: Write.
- nop: T3 only, no strobes, then T0.
- Undefined opcode: treated as nop.
- halt, or `stop` = 1 sampled in T0: go to HALT. HALT has no strobes and `run` = 0. HALT is left only by `clr`.

## Timing
- Reset: `clr` high at a rising edge forces state RESET and all outputs 0 on the next cycle, mid-instruction included. RESET moves to T0 on the first edge with `clr` low.
- Cycles per instruction, T0 to the next T0:
  - ALU and ldi: 6
  - nop: 4
  - mul/div: 7
  - ld/st: 8
- Exactly one `Rout` bit is high whenever any register drives the bus. `Rout` and `enableReg` are never both nonzero in the same cycle.
- `Read` and `Write` are never high together.
- `opCode` is 00000 outside ALU-compute states.
- Register index 0 is a normal register; it needs no special case.
- `run` is 1 in every state except HALT.

## Structure
- Package `cpu_pkg` holds:
  - the opcode localparams: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, ror 01000, rol 00111, shr 01001, shra 01010, shl 01011, mul 01111, div 10000, nop 11010, halt 11011;
  - the state enum: RESET, T0–T7, HALT;
  - the IR field-slice constants.
- The ALU opCode for an R-type instruction equals its IR opcode.
- One sub-module, `reg_onehot_dec`: 4-bit index plus enable in, 16-bit one-hot out. It is instantiated twice, once for `Rout` and once for `enableReg`.

## Test plan
- Reset, then IR = 0x28918000 (and R1,R2,R3) at T2:
  - T3 Rout = 0x0004 with Yin.
  - T4 Rout = 0x0008, opCode = 00101, Zlowin.
  - T5 enableReg = 0x0002 with Zlowout.
  - Next cycle is T0.
- ror R1,R2,R3 (opcode 01000) through the real datapath with R2 = 0x0000000F and R3 = 3 → R1 = 0xE0000001.
- ld R1, 0x55(R0) → MARin in T5, Read with MDRin in T6, enableReg = 0x0002 in T7. Next T0 occurs 8 cycles after the previous T0.
- mul R3,R4 → ZHighin and Zlowin together in T4, LOin in T5, HIin in T6.
- Halt and `stop`:
  - `stop` = 1 at T0 → HALT with `run` = 0; strobes stay 0 for 20 cycles.
  - A halt opcode gives the same result.
  - `clr` → T0 after one RESET cycle.
- `clr` asserted in T4 of an add → all outputs 0 next cycle, and no `enableReg` pulse.
- In every scenario, the checker asserts:
  - `Rout` is zero or one-hot;
  - `Read` and `Write` are never both high;
  - `Rout` and `enableReg` are never both nonzero in the same cycle.
